// File: rtl/counter_tickgen_pkg.sv
// counter_tickgen_pkg: shared source-range helpers and edge-mode encodings
package counter_tickgen_pkg;
    typedef enum logic [1:0] {
        EDGE_RISE = 2'b00,
        EDGE_FALL = 2'b01,
        EDGE_BOTH = 2'b10,
        EDGE_RSVD = 2'b11
    } edge_mode_e;

    function automatic int sel_width(input int n_int, input int n_ext, input int n_ch);
        return $clog2(n_int + n_ext + n_ch);
    endfunction

    function automatic int ext_base(input int n_int);
        return n_int;
    endfunction

    function automatic int ovf_base(input int n_int, input int n_ext);
        return n_int + n_ext;
    endfunction
endpackage

// File: rtl/counter_tickgen_ch.sv
// counter_tickgen_ch: per-channel shadow config, source select, edge qualify and prescaler
module counter_tickgen_ch
    import counter_tickgen_pkg::*;
#(
    parameter int CH      = 0,
    parameter int NUM_CH  = 4,
    parameter int NUM_INT = 2,
    parameter int NUM_EXT = 3,
    parameter int PRESC_W = 8,
    parameter int SEL_W   = 4
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic [NUM_INT-1:0] i_int_tick,
    input  logic [NUM_EXT-1:0] i_ext_lvl,
    input  logic [NUM_EXT-1:0] i_ext_prev,
    input  logic [NUM_CH-1:0]  i_cnt_ovf,
    input  logic               i_ch_en,
    input  logic [SEL_W-1:0]   i_src_sel,
    input  logic [1:0]         i_edge_mode,
    input  logic [PRESC_W-1:0] i_presc,
    output logic               o_tick,
    output logic               o_ch_start,
    output logic               o_ch_active
);
    logic [SEL_W-1:0]   sel;
    edge_mode_e         mode;
    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] cnt;
    logic               ev;
    logic               run;

    assign run = i_ch_en && o_ch_active;

    always_comb begin
        ev = 1'b0;
        for (int i = 0; i < NUM_INT; i++)
            if (sel == SEL_W'(i)) ev = i_int_tick[i];
        for (int i = 0; i < NUM_EXT; i++)
            if (sel == SEL_W'(ext_base(NUM_INT) + i))
                ev = mode == EDGE_FALL ? (!i_ext_lvl[i] && i_ext_prev[i]) :
                     mode == EDGE_BOTH ? (i_ext_lvl[i] ^ i_ext_prev[i]) :
                                         (i_ext_lvl[i] && !i_ext_prev[i]);
        for (int i = 0; i < NUM_CH; i++)
            if (sel == SEL_W'(ovf_base(NUM_INT, NUM_EXT) + i))
                ev = i_cnt_ovf[i] && (i != CH);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sel         <= '0;
            mode        <= EDGE_RISE;
            presc       <= '0;
            cnt         <= '0;
            o_tick      <= 1'b0;
            o_ch_start  <= 1'b0;
            o_ch_active <= 1'b0;
        end else begin
            if (!run) begin
                sel   <= i_src_sel;
                mode  <= edge_mode_e'(i_edge_mode);
                presc <= i_presc;
            end
            o_ch_start  <= i_ch_en && !o_ch_active;
            o_ch_active <= i_ch_en;
            o_tick      <= run && ev && cnt == presc;
            cnt         <= !run ? '0 : !ev ? cnt : cnt == presc ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/counter_tickgen.sv
// counter_tickgen: shared external synchronisers feeding NUM_CH tick-generating channels
module counter_tickgen
    import counter_tickgen_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int NUM_INT     = 2,
    parameter int NUM_EXT     = 3,
    parameter int PRESC_W     = 8,
    parameter int SYNC_STAGES = 2,
    parameter int SEL_W       = sel_width(NUM_INT, NUM_EXT, NUM_CH)
) (
    input  logic                      i_clk,
    input  logic                      i_rstn,
    input  logic [NUM_INT-1:0]        i_int_tick,
    input  logic [NUM_EXT-1:0]        i_ext_src,
    input  logic [NUM_CH-1:0]         i_cnt_ovf,
    input  logic [NUM_CH-1:0]         i_ch_en,
    input  logic [NUM_CH*SEL_W-1:0]   i_src_sel,
    input  logic [NUM_CH*2-1:0]       i_edge_mode,
    input  logic [NUM_CH*PRESC_W-1:0] i_presc,
    output logic [NUM_CH-1:0]         o_tick,
    output logic [NUM_CH-1:0]         o_ch_start,
    output logic [NUM_CH-1:0]         o_ch_active
);
    logic [SYNC_STAGES-1:0][NUM_EXT-1:0] sync;
    logic [NUM_EXT-1:0]                  hist;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sync <= '0;
            hist <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], i_ext_src};
            hist <= sync[SYNC_STAGES-1];
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        counter_tickgen_ch #(
            .CH      (c),
            .NUM_CH  (NUM_CH),
            .NUM_INT (NUM_INT),
            .NUM_EXT (NUM_EXT),
            .PRESC_W (PRESC_W),
            .SEL_W   (SEL_W)
        ) u_ch (
            .i_clk       (i_clk),
            .i_rstn      (i_rstn),
            .i_int_tick  (i_int_tick),
            .i_ext_lvl   (sync[SYNC_STAGES-1]),
            .i_ext_prev  (hist),
            .i_cnt_ovf   (i_cnt_ovf),
            .i_ch_en     (i_ch_en[c]),
            .i_src_sel   (i_src_sel[c*SEL_W +: SEL_W]),
            .i_edge_mode (i_edge_mode[c*2 +: 2]),
            .i_presc     (i_presc[c*PRESC_W +: PRESC_W]),
            .o_tick      (o_tick[c]),
            .o_ch_start  (o_ch_start[c]),
            .o_ch_active (o_ch_active[c])
        );
    end
endmodule

// File: tb/tb_counter_tickgen.sv
// tb_counter_tickgen: directed stimulus with a per-channel expected-cycle scoreboard
module tb_counter_tickgen;
    localparam int NUM_CH = 4, NUM_INT = 2, NUM_EXT = 3, PRESC_W = 8, SYNC_STAGES = 2, SEL_W = 4;

    logic                      clk = 1'b0;
    logic                      rstn = 1'b0;
    logic [NUM_INT-1:0]        int_tick = '0;
    logic [NUM_EXT-1:0]        ext = '0;
    logic [NUM_CH-1:0]         ovf = '0;
    logic [NUM_CH-1:0]         en = '0;
    logic [NUM_CH*SEL_W-1:0]   sel = '0;
    logic [NUM_CH*2-1:0]       mode = '0;
    logic [NUM_CH*PRESC_W-1:0] presc = '0;
    logic [NUM_CH-1:0]         tick, start, active;

    int cyc = 0;
    int vecs = 0;
    int errs = 0;
    int tick_q[NUM_CH][$];
    int start_q[NUM_CH][$];

    counter_tickgen #(
        .NUM_CH(NUM_CH), .NUM_INT(NUM_INT), .NUM_EXT(NUM_EXT),
        .PRESC_W(PRESC_W), .SYNC_STAGES(SYNC_STAGES), .SEL_W(SEL_W)
    ) dut (
        .i_clk(clk), .i_rstn(rstn), .i_int_tick(int_tick), .i_ext_src(ext),
        .i_cnt_ovf(ovf), .i_ch_en(en), .i_src_sel(sel), .i_edge_mode(mode),
        .i_presc(presc), .o_tick(tick), .o_ch_start(start), .o_ch_active(active)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) ovf <= tick;

    always @(negedge clk) begin
        int e;
        if (rstn) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (tick[c]) begin
                    vecs++;
                    if (tick_q[c].size() == 0) begin
                        errs++;
                        $display("FAIL tick%0d: unexpected tick at cycle %0d, expected none", c, cyc);
                    end else begin
                        e = tick_q[c].pop_front();
                        if (e != cyc) begin
                            errs++;
                            $display("FAIL tick%0d: tick at cycle %0d, expected cycle %0d", c, cyc, e);
                        end
                    end
                end
                if (start[c]) begin
                    vecs++;
                    if (start_q[c].size() == 0) begin
                        errs++;
                        $display("FAIL start%0d: unexpected start at cycle %0d, expected none", c, cyc);
                    end else begin
                        e = start_q[c].pop_front();
                        if (e != cyc) begin
                            errs++;
                            $display("FAIL start%0d: start at cycle %0d, expected cycle %0d", c, cyc, e);
                        end
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_empty(input string tag);
        for (int c = 0; c < NUM_CH; c++) begin
            check($sformatf("%s pending ticks ch%0d", tag, c), tick_q[c].size(), 0);
            check($sformatf("%s pending starts ch%0d", tag, c), start_q[c].size(), 0);
        end
    endtask

    task automatic cfg(input int c, input int s, input int m, input int p);
        sel[c*SEL_W +: SEL_W]       = SEL_W'(s);
        mode[c*2 +: 2]              = 2'(m);
        presc[c*PRESC_W +: PRESC_W] = PRESC_W'(p);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        idle(3);
        check("reset o_tick", int'(tick), 0);
        check("reset o_ch_start", int'(start), 0);
        check("reset o_ch_active", int'(active), 0);
        rstn = 1'b1;
        idle(2);

        // ch0: internal strobe 0, divide by 4
        cfg(0, 0, 0, 3);
        en[0] = 1'b1;
        start_q[0].push_back(cyc + 1);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 1) check("ch0 active after enable", int'(active[0]), 1);
            int_tick[0] = 1'b1;
            if (i % 4 == 0) tick_q[0].push_back(cyc + 1);
        end
        // presc change while enabled must not take effect
        cfg(0, 0, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i % 4 == 0) tick_q[0].push_back(cyc + 1);
        end
        @(negedge clk);
        en[0] = 1'b0;
        int_tick[0] = 1'b0;
        @(negedge clk);
        check("ch0 inactive after disable", int'(active[0]), 0);
        en[0] = 1'b1;
        start_q[0].push_back(cyc + 1);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            int_tick[0] = 1'b1;
            tick_q[0].push_back(cyc + 1);
        end
        // enable fall together with a qualifying strobe: no tick
        @(negedge clk);
        en[0] = 1'b0;
        @(negedge clk);
        int_tick[0] = 1'b0;
        idle(4);
        check_empty("strobe");

        // ch1: external pin 0, both edges
        cfg(1, NUM_INT, 2, 0);
        en[1] = 1'b1;
        start_q[1].push_back(cyc + 1);
        idle(2);
        for (int j = 0; j < 4; j++) begin
            ext[0] = ~ext[0];
            tick_q[1].push_back(cyc + SYNC_STAGES + 1);
            idle(5);
        end
        en[1] = 1'b0;
        @(negedge clk);
        cfg(1, NUM_INT, 1, 0);
        en[1] = 1'b1;
        start_q[1].push_back(cyc + 1);
        idle(2);
        ext[0] = 1'b1;
        idle(5);
        ext[0] = 1'b0;
        tick_q[1].push_back(cyc + SYNC_STAGES + 1);
        idle(6);
        en[1] = 1'b0;
        idle(2);
        check_empty("ext");

        // cascade: ch2 counts ch0 overflows /2, ch3 selects its own overflow
        cfg(0, 0, 0, 1);
        cfg(2, NUM_INT + NUM_EXT + 0, 0, 1);
        cfg(3, NUM_INT + NUM_EXT + 3, 0, 0);
        en[0] = 1'b1;
        en[2] = 1'b1;
        en[3] = 1'b1;
        start_q[0].push_back(cyc + 1);
        start_q[2].push_back(cyc + 1);
        start_q[3].push_back(cyc + 1);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            int_tick[0] = 1'b1;
            if (i % 2 == 0) tick_q[0].push_back(cyc + 1);
            if (i % 4 == 0) tick_q[2].push_back(cyc + 3);
        end
        @(negedge clk);
        int_tick[0] = 1'b0;
        idle(5);
        en = '0;
        idle(2);
        check_empty("cascade");

        // async reset mid-count, enable held high across release
        cfg(0, 0, 0, 5);
        en[0] = 1'b1;
        start_q[0].push_back(cyc + 1);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            int_tick[0] = 1'b1;
        end
        @(negedge clk);
        check("ch0 active before reset", int'(active[0]), 1);
        rstn = 1'b0;
        #1;
        check("async reset o_tick", int'(tick), 0);
        check("async reset o_ch_start", int'(start), 0);
        check("async reset o_ch_active", int'(active), 0);
        idle(2);
        rstn = 1'b1;
        start_q[0].push_back(cyc + 1);
        for (int i = 1; i <= 8; i++) begin
            if (i == 7) tick_q[0].push_back(cyc + 1);
            @(negedge clk);
        end
        int_tick[0] = 1'b0;
        en[0] = 1'b0;
        idle(3);
        check_empty("reset");

        // external pin high across reset release, channel enabled: one rise
        cfg(1, NUM_INT, 0, 0);
        ext[0] = 1'b1;
        idle(4);
        rstn = 1'b0;
        en[1] = 1'b1;
        idle(2);
        rstn = 1'b1;
        start_q[1].push_back(cyc + 1);
        tick_q[1].push_back(cyc + SYNC_STAGES + 1);
        idle(10);
        en[1] = 1'b0;
        idle(2);
        check_empty("final");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
